// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: ALU operation encodings and default width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Encoding of the add/subtract select bit
  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Default datapath width
  localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder: valid/ready in, valid/ready out.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer, in_ready back to the producer.
// Ports: in_valid/in_ready/a/b/sub (operand beat), out_valid/out_ready/
//        sum/carry/overflow/zero/negative (result beat).
interface pipelined_adder_if #(
  parameter int WIDTH = cpu_pkg::DATA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  // Producer/consumer side
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/adder_chunk.sv
// Combinational C-bit adder slice with carry-in.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a_i/b_i operands, c_i carry-in, sum_o, cout_o carry-out,
//        cmsb_o carry into the MSB (for signed overflow detection).
module adder_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a_i,
  input  logic [C-1:0] b_i,
  input  logic         c_i,
  output logic [C-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);
  logic [C:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, c_i};
  assign sum_o  = full[C-1:0];
  assign cout_o = full[C];
  // The MSB sum bit is a^b^cin, so the carry into it falls out directly;
  // this also holds for a 1-bit slice.
  assign cmsb_o = full[C-1] ^ a_i[C-1] ^ b_i[C-1];
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, one C=WIDTH/STAGES chunk per stage, with flags.
// Latency: STAGES cycles accept-to-out_valid; one beat per cycle throughput.
// Backpressure: ready_k = !valid_k || ready_k+1; stalled stages hold contents.
// Ports: clk, rst_n (async active-low), bus (slave side of pipelined_adder_if).
// WIDTH must be a multiple of STAGES, STAGES >= 1.
module pipelined_adder
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DATA_WIDTH,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int C = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  // Stage registers: each stage holds one complete in-flight beat
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];   // B already inverted for subtraction
  logic [WIDTH-1:0] sum_q   [STAGES];   // chunks 0..k valid after stage k
  logic             carry_q [STAGES];
  logic             ovf_q, zero_q, neg_q;

  logic [STAGES:0]  rdy;

  // What each stage would load: previous stage contents (or the input bus)
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];

  logic [C-1:0]     chunk_a    [STAGES];
  logic [C-1:0]     chunk_b    [STAGES];
  logic [C-1:0]     chunk_sum  [STAGES];
  logic             chunk_cout [STAGES];
  logic             chunk_cmsb [STAGES];

  logic [WIDTH-1:0] sum_d [STAGES];
  logic             ovf_d, zero_d, neg_d;

  // Ready ripples backwards from the consumer in the same cycle
  always_comb begin
    rdy[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !valid_q[k] || rdy[k+1];
    end
  end

  always_comb begin
    src_v[0] = bus.in_valid;
    src_a[0] = bus.a;
    src_b[0] = (bus.sub == ALU_OP_SUB) ? ~bus.b : bus.b;
    src_s[0] = '0;
    src_c[0] = bus.sub;   // +1 of the two's-complement negation
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = carry_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk_a[k] = src_a[k][k*C +: C];
      chunk_b[k] = src_b[k][k*C +: C];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_chunk
    adder_chunk #(.C(C)) u_chunk (
      .a_i    (chunk_a[g]),
      .b_i    (chunk_b[g]),
      .c_i    (src_c[g]),
      .sum_o  (chunk_sum[g]),
      .cout_o (chunk_cout[g]),
      .cmsb_o (chunk_cmsb[g])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]              = src_s[k];
      sum_d[k][k*C +: C]    = chunk_sum[k];
    end
    ovf_d  = chunk_cmsb[L] ^ chunk_cout[L];
    zero_d = ~|sum_d[L];
    neg_d  = sum_d[L][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= src_v[k];
          // Payload only moves with a valid beat, so the last result stays
          // visible (and stable) after it has been consumed.
          if (src_v[k]) begin
            a_q[k]     <= src_a[k];
            b_q[k]     <= src_b[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= chunk_cout[k];
          end
        end
      end
      if (rdy[L] && src_v[L]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = valid_q[L];
  assign bus.sum       = sum_q[L];
  assign bus.carry     = carry_q[L];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at 8/2 and 16/4 with a queue scoreboard per instance.
// Latency: n/a.
// Backpressure: out_ready driven by the bench (fixed, stalled or random).
module tb_pipelined_adder;
  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   rnd_done = 1'b0;

  res_t q8[$];
  res_t q16[$];

  pipelined_adder_if #(.WIDTH(8))  i8 ();
  pipelined_adder_if #(.WIDTH(16)) i16 ();

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-width add, independent of chunking
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    logic [15:0] mask, bp, sm;
    logic [16:0] full;
    res_t r;
    mask    = (w == 16) ? 16'hFFFF : 16'h00FF;
    bp      = (s ? ~b : b) & mask;
    full    = {1'b0, a & mask} + {1'b0, bp} + {16'h0, s};
    sm      = full[15:0] & mask;
    r.sum   = sm;
    r.carry = full[w];
    r.ovf   = (a[w-1] == bp[w-1]) && (sm[w-1] != a[w-1]);
    r.zero  = (sm == 16'h0);
    r.neg   = sm[w-1];
    return r;
  endfunction

  function automatic res_t obs8();
    res_t r;
    r.sum = {8'h00, i8.sum}; r.carry = i8.carry; r.ovf = i8.overflow;
    r.zero = i8.zero; r.neg = i8.negative;
    return r;
  endfunction

  function automatic res_t obs16();
    res_t r;
    r.sum = i16.sum; r.carry = i16.carry; r.ovf = i16.overflow;
    r.zero = i16.zero; r.neg = i16.negative;
    return r;
  endfunction

  // Monitors: scoreboard compare on delivery, stability check while stalled
  res_t m8_held, m16_held;
  bit   m8_hold = 1'b0, m16_hold = 1'b0;

  always @(negedge clk) begin : mon8
    res_t o;
    o = obs8();
    if (!rst_n) m8_hold = 1'b0;
    else begin
      if (m8_hold) begin
        chk("stall_valid8", 32'(i8.out_valid), 32'd1);
        chk("stall_data8", {12'h0, o}, {12'h0, m8_held});
      end
      if (i8.out_valid && i8.out_ready) begin
        chk("sb8_pending", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) chk("res8", {12'h0, o}, {12'h0, q8.pop_front()});
      end
      m8_hold = i8.out_valid && !i8.out_ready;
      m8_held = o;
    end
  end

  always @(negedge clk) begin : mon16
    res_t o;
    o = obs16();
    if (!rst_n) m16_hold = 1'b0;
    else begin
      if (m16_hold) begin
        chk("stall_valid16", 32'(i16.out_valid), 32'd1);
        chk("stall_data16", {12'h0, o}, {12'h0, m16_held});
      end
      if (i16.out_valid && i16.out_ready) begin
        chk("sb16_pending", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) chk("res16", {12'h0, o}, {12'h0, q16.pop_front()});
      end
      m16_hold = i16.out_valid && !i16.out_ready;
      m16_held = o;
    end
  end

  // Offer one beat (called just after a rising edge); returns just after the accepting edge
  task automatic send(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic s);
    if (wide) begin i16.in_valid = 1'b1; i16.a = a; i16.b = b; i16.sub = s; end
    else begin i8.in_valid = 1'b1; i8.a = a[7:0]; i8.b = b[7:0]; i8.sub = s; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wide ? i16.in_ready : i8.in_ready) begin
        if (wide) q16.push_back(model(16, a, b, s));
        else      q8.push_back(model(8, a, b, s));
        @(posedge clk); #1;
        if (wide) i16.in_valid = 1'b0; else i8.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_accept_timeout", 32'd0, 32'd1);
    if (wide) i16.in_valid = 1'b0; else i8.in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid is seen
  task automatic wait_out(input bit wide, output int lat);
    int n;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wide ? i16.out_valid : i8.out_valid) begin lat = n; return; end
      @(posedge clk); #1;
      n++;
    end
    lat = -1;
  endtask

  task automatic directed(input string tag, input bit wide, input logic [15:0] a,
                          input logic [15:0] b, input logic s, input logic [15:0] esum,
                          input logic ec, input logic ev, input logic ez, input logic en,
                          input int elat);
    int lat;
    res_t o;
    send(wide, a, b, s);
    wait_out(wide, lat);
    chk({tag, "_lat"}, lat, elat);
    o = wide ? obs16() : obs8();
    chk({tag, "_res"}, {12'h0, o}, {12'h0, esum, ec, ev, ez, en});
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit wide);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((wide ? q16.size() : q8.size()) == 0) break;
    end
    chk(wide ? "drain16" : "drain8", wide ? q16.size() : q8.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i8.in_valid = 0;  i8.a = '0;  i8.b = '0;  i8.sub = 0;  i8.out_ready = 0;
    i16.in_valid = 0; i16.a = '0; i16.b = '0; i16.sub = 0; i16.out_ready = 0;

    // Reset state
    #12;
    chk("rst_out8", {19'h0, i8.out_valid, obs8()}, 32'h0);
    chk("rst_out16", {19'h0, i16.out_valid, obs16()}, 32'h0);
    #5 rst_n = 1'b1;   // just after the rising edge at t=15
    #1;
    chk("rst_in_ready8", 32'(i8.in_ready), 32'd1);
    chk("rst_in_ready16", 32'(i16.in_ready), 32'd1);
    i8.out_ready = 1'b1;
    i16.out_ready = 1'b1;

    // Directed 8/2 cases
    directed("aa55", 0, 16'h00AA, 16'h0055, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    directed("ff01", 0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    directed("ff7f", 0, 16'h00FF, 16'h007F, 1'b0, 16'h007E, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    directed("s8001", 0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    directed("s0507", 0, 16'h0005, 16'h0007, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    drain(0);

    // Six back-to-back adds; consumer stalls 3 cycles once two beats are held
    fork
      begin
        for (int k = 0; k < 6; k++) send(0, 16'(16 * k + 3), 16'(37 * k + 250), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 i8.out_ready = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(i8.in_ready), 32'd0);
        chk("full_out_valid", 32'(i8.out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 i8.out_ready = 1'b1;
      end
    join
    drain(0);

    // Reset with two beats in flight
    send(0, 16'h0011, 16'h0022, 1'b0);
    send(0, 16'h0033, 16'h0044, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out8", {19'h0, i8.out_valid, obs8()}, 32'h0);
    q8.delete();
    q16.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("midrst_in_ready8", 32'(i8.in_ready), 32'd1);
    directed("post_rst", 0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale8", 32'(i8.out_valid), 32'd0);

    // 16/4 directed
    directed("w00ff", 1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    directed("wffff", 1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    drain(1);

    // 16/4 random sweep with random backpressure
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          send(1, 16'($urandom), 16'($urandom), 1'($urandom));
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          i16.out_ready = ($urandom_range(0, 3) != 0);
        end
        i16.out_ready = 1'b1;
      end
    join
    drain(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit for the CPU datapath. It replaces the single-cycle 8-bit adder wherever the operand width or clock target needs a registered carry chain. The unit splits a WIDTH-bit operation into STAGES equal chunks, one chunk per pipeline stage. It carries operands and partial results through a valid/ready pipeline and emits the result with carry, overflow, zero and negative flags.

## Interface
- WIDTH, 8: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2: pipeline depth and chunk count; chunk width C = WIDTH/STAGES; STAGES ≥ 1.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  unit accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result beat available.
- out_ready  in  1  consumer takes result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry  out  1  carry out of MSB (for sub: 1 = no borrow).
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.
- negative  out  1  sum[WIDTH−1].

## Operation
- Beat accepted when in_valid && in_ready; beat delivered when out_valid && out_ready.
- Subtraction computed as A + ~B + 1: stage 0 carry-in = sub.
- Stage k (0..STAGES−1) adds chunk k, bits [(k+1)C−1 : kC], of A and B' (B or ~B) plus the carry registered by stage k−1. It registers the C-bit partial sum, the chunk carry-out and a valid bit.
- Unprocessed chunks of A/B' travel forward with the beat. Completed partial sums also travel forward, so each stage holds one complete in-flight beat.
- Final stage also registers overflow = carry into MSB XOR carry out of MSB, zero, and negative.
- Per-stage ready: ready_k = !valid_k || ready_(k+1); ready_STAGES = out_ready; in_ready = ready_0.
- Stalled stage holds all contents unchanged; out_valid and all result outputs stay stable until out_ready.
- Results emerge strictly in acceptance order; no beat is dropped or duplicated.
- STAGES = 1 degenerates to one registered full-width adder.

## Timing
- Reset (rst_n low, asynchronous): all stage valids 0. out_valid 0, sum 0, carry 0, overflow 0, zero 0, negative 0. in_ready 1 once rst_n is high.
- Reset mid-operation discards every in-flight beat; nothing is emitted after release except beats accepted after release.
- Latency: a beat accepted at edge n gives out_valid high after edge n+STAGES−1+1, i.e. STAGES cycles, with no stall.
- Throughput: one beat per cycle when out_ready is held high.
- Full pipeline with out_ready low: in_ready low in the same cycle (combinational path out_ready → in_ready).
- Simultaneous accept and deliver while full: allowed; occupancy unchanged.
- Wrap-around: sum is truncated to WIDTH bits; carry reports the lost bit.

## Structure
- Shared package cpu_pkg: constants ALU_OP_ADD = 1'b0 and ALU_OP_SUB = 1'b1, plus the default datapath width constant (8).
- Sub-module adder_chunk: combinational C-bit adder with carry-in. Outputs are sum, carry-out and the carry into its MSB, used for the overflow computation. Instantiate it once per stage in a generate loop.
- pipelined_adder contains only the stage registers, valid/ready logic and flag logic.

## Test plan
Run at WIDTH=8, STAGES=2 unless noted.
- Add 0xAA + 0x55 -> sum 0xFF, carry 0, overflow 0, negative 1, zero 0; out_valid exactly 2 cycles after accept.
- Add 0xFF + 0x01 -> sum 0x00, carry 1, zero 1. Add 0xFF + 0x7F -> sum 0x7E, carry 1, overflow 0.
- Sub 0x80 − 0x01 -> sum 0x7F, carry 1, overflow 1. Sub 0x05 − 0x07 -> sum 0xFE, carry 0, negative 1.
- Stream 6 back-to-back adds with out_ready low for 3 cycles mid-stream:
  - in_ready drops once 2 beats are held;
  - all 6 results arrive in order, with outputs stable during the stall.
- Assert rst_n low while 2 beats are in flight -> out_valid and all outputs 0 immediately. After release, 0x01 + 0x01 -> 0x02 at latency 2, and no stale beat appears.
- WIDTH=16, STAGES=4: 0x00FF + 0x0001 -> 0x0100 (carry crosses chunks), 0xFFFF + 0x0001 -> 0x0000 with carry 1; latency 4; random 1000-beat sweep against a reference model.
